sram_arbiter: RTL and testbench

Two-master arbiter sharing one SRAM-like memory port between the instruction-fetch requester (IFU) and the data requester (EXE/MEM). It accepts requests through req/addr_ok handshakes and forwards the granted request to the single memory port. It tracks outstanding transactions in an in-order owner-tag FIFO and routes each data_ok/rdata back to the master that issued it. It sits between the pipeline front/back ends and the memory bridge, and supports discarding in-flight fetches on pipeline flush.

---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_arbiter_if.sv | 49 ++++
 rtl/sram_arb_fifo.sv | 83 ++++++++
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared owner encodings, tag-FIFO entry type and grant FSM states for sram_arbiter.
package sram_arb_pkg;

  localparam logic       OWNER_INST = 1'b0;
  localparam logic       OWNER_DATA = 1'b1;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam int         CNT_W      = 3;

  typedef struct packed {
    logic valid;
    logic owner;
    logic discard;
  } tag_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the IFU, EXE/MEM and memory-port signals; slave = arbiter view, master = environment view.
interface sram_arbiter_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_cancel;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sram_arb_fifo.sv
// In-order owner-tag FIFO: push on handshake, pop on response, broadcast discard of stored fetch tags.
module sram_arb_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             push_owner_i,
  input  logic             pop_i,
  input  logic             discard_inst_i,
  output tag_t             head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t             mem_q [DEPTH];
  tag_t             mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & (count_q != {CNT_W{1'b0}});

  // Next-state: discard marks only entries already stored, so the new push stays clean
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (discard_inst_i && mem_q[i].valid && (mem_q[i].owner == OWNER_INST)) begin
        mem_d[i].discard = 1'b1;
      end else begin
        mem_d[i].discard = mem_q[i].discard;
      end
    end
    if (pop_ok_s) begin
      mem_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d              = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = '{valid: 1'b1, owner: push_owner_i, discard: 1'b0};
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master SRAM-port arbiter with grant lock, field mux and in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over inst.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic             lock_owner_q, lock_owner_d;
  logic             grant_s, granted_req_s, mem_req_s, push_s, pop_s, deliver_s, full_s;
  logic             head_cancel_s;
  tag_t             head_s;
  logic [CNT_W-1:0] count_s;
`ifdef SRAM_ARB_RR_EN
  logic             rr_ptr_q, rr_ptr_d;
`endif

  // Grant selection: the lock pins the owner until its address is accepted
  always_comb begin
    grant_s = OWNER_INST;
    case (state_q)
      ST_LOCKED: grant_s = lock_owner_q;
      ST_IDLE: begin
`ifdef SRAM_ARB_RR_EN
        if (bus.data_req && bus.inst_req) begin
          grant_s = rr_ptr_q;
        end else if (bus.data_req) begin
          grant_s = OWNER_DATA;
        end else begin
          grant_s = OWNER_INST;
        end
`else
        if (bus.data_req) begin
          grant_s = OWNER_DATA;
        end else begin
          grant_s = OWNER_INST;
        end
`endif
      end
      default: grant_s = OWNER_INST;
    endcase
  end

  assign granted_req_s    = (grant_s == OWNER_DATA) ? bus.data_req : bus.inst_req;
  assign mem_req_s        = granted_req_s & ~full_s;
  assign push_s           = mem_req_s & bus.mem_addr_ok;
  assign bus.mem_req      = mem_req_s;
  assign bus.inst_addr_ok = push_s & (grant_s == OWNER_INST);
  assign bus.data_addr_ok = push_s & (grant_s == OWNER_DATA);

  // Grant FSM next state
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_s && !bus.mem_addr_ok) begin
          state_d      = ST_LOCKED;
          lock_owner_d = grant_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (bus.mem_addr_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Field mux toward memory; fetches are always word reads
  always_comb begin
    bus.mem_wr    = 1'b0;
    bus.mem_size  = 2'b00;
    bus.mem_wstrb = 4'b0000;
    bus.mem_addr  = 32'h0000_0000;
    bus.mem_wdata = 32'h0000_0000;
    if (grant_s == OWNER_DATA) begin
      bus.mem_wr    = bus.data_wr;
      bus.mem_size  = bus.data_size;
      bus.mem_wstrb = bus.data_wstrb;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
    end else if (bus.inst_req) begin
      bus.mem_size = SIZE_WORD;
      bus.mem_addr = bus.inst_addr;
    end else begin
      bus.mem_addr = 32'h0000_0000;
    end
  end

  // A cancel in the popping cycle also kills the fetch response at the head
  assign pop_s            = bus.mem_data_ok & (count_s != {CNT_W{1'b0}});
  assign head_cancel_s    = bus.inst_cancel & (head_s.owner == OWNER_INST);
  assign deliver_s        = pop_s & head_s.valid & ~head_s.discard & ~head_cancel_s;
  assign bus.inst_data_ok = deliver_s & (head_s.owner == OWNER_INST);
  assign bus.data_data_ok = deliver_s & (head_s.owner == OWNER_DATA);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  sram_arb_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .push_i         (push_s),
    .push_owner_i   (grant_s),
    .pop_i          (pop_s),
    .discard_inst_i (bus.inst_cancel),
    .head_o         (head_s),
    .count_o        (count_s),
    .full_o         (full_s)
  );

  // Grant FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lock_owner_q <= OWNER_INST;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Preference passes to the other master once the preferred one completes a handshake
  always_comb begin
    if (push_s && (grant_s == rr_ptr_q)) begin
      rr_ptr_d = ~rr_ptr_q;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= OWNER_INST;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int OUTS = 2;
`ifdef SRAM_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  typedef struct packed {
    logic owner;
    logic disc;
  } mtag_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  sram_arbiter_if bus();

  sram_arbiter #(.OUTSTANDING(OUTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ctl();
    return {bus.mem_req, bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok};
  endfunction

  function automatic logic [70:0] fields();
    return {bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.inst_req = 1'b0; bus.inst_addr = 32'h0; bus.inst_cancel = 1'b0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'b00; bus.data_wstrb = 4'h0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  task automatic set_inst(input logic [31:0] a);
    bus.inst_req = 1'b1; bus.inst_addr = a;
  endtask

  task automatic set_data(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] wd);
    bus.data_req = 1'b1; bus.data_wr = wr; bus.data_size = sz; bus.data_wstrb = st;
    bus.data_addr = a; bus.data_wdata = wd;
  endtask

  task automatic test_reset();
    logic [139:0] all_o;
    reset = 1'b1;
    idle_in();
    tick(); tick(); #4;
    all_o = {fields(), ctl(), bus.inst_rdata, bus.data_rdata, 1'b0};
    vectors++;
    if (all_o !== 140'h0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", all_o); end
    tick();
    reset = 1'b0;
    #4;
    vectors++;
    if (ctl() !== 5'b00000) begin miscompares++; $display("FAIL reset_release: got %b want 00000", ctl()); end
    tick();
  endtask

  task automatic test_priority();
    logic first_data;
    first_data = ~RR;
    idle_in();
    set_inst(32'h1c00_0000); set_data(1'b0, 2'd2, 4'hf, 32'h0000_0200, 32'h0);
    bus.mem_addr_ok = 1'b1;
    #4;
    vectors++;
    if (ctl() !== (first_data ? 5'b10100 : 5'b11000)) begin
      miscompares++; $display("FAIL prio_first_ctl: got %b", ctl()); end
    vectors++;
    if (bus.mem_addr !== (first_data ? 32'h0000_0200 : 32'h1c00_0000)) begin
      miscompares++; $display("FAIL prio_first_addr: got %h", bus.mem_addr); end
    tick();
    if (first_data) bus.data_req = 1'b0; else bus.inst_req = 1'b0;
    #4;
    vectors++;
    if (ctl() !== (first_data ? 5'b11000 : 5'b10100)) begin
      miscompares++; $display("FAIL prio_second_ctl: got %b", ctl()); end
    vectors++;
    if (bus.mem_size !== 2'b10) begin miscompares++; $display("FAIL prio_size: got %b want 10", bus.mem_size); end
    tick();
    idle_in();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'haaaa_0001;
    #4;
    vectors++;
    if ({ctl(), bus.data_rdata} !== {(first_data ? 5'b00001 : 5'b00010), 32'haaaa_0001}) begin
      miscompares++; $display("FAIL prio_resp1: got %b %h", ctl(), bus.data_rdata); end
    tick();
    bus.mem_rdata = 32'hbbbb_0002;
    #4;
    vectors++;
    if ({ctl(), bus.inst_rdata} !== {(first_data ? 5'b00010 : 5'b00001), 32'hbbbb_0002}) begin
      miscompares++; $display("FAIL prio_resp2: got %b %h", ctl(), bus.inst_rdata); end
    tick();
    idle_in();
  endtask

  task automatic test_lock();
    idle_in();
    set_inst(32'h1c00_0040);
    #4;
    vectors++;
    if ({ctl(), bus.mem_addr} !== {5'b10000, 32'h1c00_0040}) begin
      miscompares++; $display("FAIL lock_start: got %b %h", ctl(), bus.mem_addr); end
    tick();
    set_data(1'b1, 2'd0, 4'b0100, 32'h0000_0302, 32'h00cc_0000);
    for (int k = 0; k < 2; k++) begin
      #4;
      vectors++;
      if ({ctl(), bus.mem_wr, bus.mem_addr} !== {5'b10000, 1'b0, 32'h1c00_0040}) begin
        miscompares++; $display("FAIL lock_hold: got %b %b %h", ctl(), bus.mem_wr, bus.mem_addr); end
      tick();
    end
    bus.mem_addr_ok = 1'b1;
    #4;
    vectors++;
    if (ctl() !== 5'b11000) begin miscompares++; $display("FAIL lock_accept: got %b want 11000", ctl()); end
    tick();
    bus.inst_req = 1'b0;
    #4;
    vectors++;
    if ({ctl(), fields()} !== {5'b10100, 1'b1, 2'd0, 4'b0100, 32'h0000_0302, 32'h00cc_0000}) begin
      miscompares++; $display("FAIL lock_data_fields: got %b %h", ctl(), fields()); end
    tick();
    idle_in();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1;
    #4;
    vectors++;
    if (ctl() !== 5'b00010) begin miscompares++; $display("FAIL lock_resp_inst: got %b want 00010", ctl()); end
    tick(); #4;
    vectors++;
    if (ctl() !== 5'b00001) begin miscompares++; $display("FAIL lock_resp_data: got %b want 00001", ctl()); end
    tick();
    idle_in();
  endtask

  task automatic test_full();
    idle_in();
    bus.mem_addr_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_inst(32'h1c00_0100 + 32'(4 * k));
      #4;
      vectors++;
      if (ctl() !== 5'b11000) begin miscompares++; $display("FAIL full_fill%0d: got %b want 11000", k, ctl()); end
      tick();
    end
    set_inst(32'h1c00_0108);
    #4;
    vectors++;
    if (ctl() !== 5'b00000) begin miscompares++; $display("FAIL full_block: got %b want 00000", ctl()); end
    tick();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000_0a0a;
    #4;
    vectors++;
    if (ctl() !== 5'b00010) begin miscompares++; $display("FAIL full_pop_cycle: got %b want 00010", ctl()); end
    tick();
    bus.mem_data_ok = 1'b0;
    #4;
    vectors++;
    if ({ctl(), bus.mem_addr} !== {5'b11000, 32'h1c00_0108}) begin
      miscompares++; $display("FAIL full_reissue: got %b %h", ctl(), bus.mem_addr); end
    tick();
    idle_in();
    bus.mem_data_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #4;
      vectors++;
      if (ctl() !== 5'b00010) begin miscompares++; $display("FAIL full_drain%0d: got %b want 00010", k, ctl()); end
      tick();
    end
    idle_in();
  endtask

  task automatic test_cancel();
    idle_in();
    bus.mem_addr_ok = 1'b1;
    set_inst(32'h1c00_0200); tick();
    set_inst(32'h1c00_0204); tick();
    bus.inst_req = 1'b0; bus.inst_cancel = 1'b1;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000_0011;
    #4;
    vectors++;
    if (ctl() !== 5'b00000) begin miscompares++; $display("FAIL cancel_head: got %b want 00000", ctl()); end
    tick();
    bus.inst_cancel = 1'b0; bus.mem_data_ok = 1'b0;
    set_inst(32'h1c00_8000);
    #4;
    vectors++;
    if (ctl() !== 5'b11000) begin miscompares++; $display("FAIL cancel_newfetch: got %b want 11000", ctl()); end
    tick();
    idle_in();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000_0022;
    #4;
    vectors++;
    if (ctl() !== 5'b00000) begin miscompares++; $display("FAIL cancel_second: got %b want 00000", ctl()); end
    tick();
    bus.mem_rdata = 32'h0000_0033;
    #4;
    vectors++;
    if ({ctl(), bus.inst_rdata} !== {5'b00010, 32'h0000_0033}) begin
      miscompares++; $display("FAIL cancel_third: got %b %h", ctl(), bus.inst_rdata); end
    tick();
    idle_in();
    bus.mem_addr_ok = 1'b1;
    set_data(1'b0, 2'd2, 4'hf, 32'h0000_0400, 32'h0);
    tick();
    bus.data_req = 1'b0; bus.inst_cancel = 1'b1;
    set_inst(32'h1c00_c000);
    #4;
    vectors++;
    if (ctl() !== 5'b11000) begin miscompares++; $display("FAIL cancel_samecycle_push: got %b want 11000", ctl()); end
    tick();
    idle_in();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000_0044;
    #4;
    vectors++;
    if (ctl() !== 5'b00001) begin miscompares++; $display("FAIL cancel_data_kept: got %b want 00001", ctl()); end
    tick(); #4;
    vectors++;
    if (ctl() !== 5'b00010) begin miscompares++; $display("FAIL cancel_push_kept: got %b want 00010", ctl()); end
    tick();
    idle_in();
  endtask

  task automatic test_reset_mid();
    logic [139:0] all_o;
    idle_in();
    bus.mem_addr_ok = 1'b1;
    set_inst(32'h1c00_0300); tick();
    bus.mem_addr_ok = 1'b0;
    set_inst(32'h1c00_0304);
    #4;
    vectors++;
    if (ctl() !== 5'b10000) begin miscompares++; $display("FAIL rmid_locked: got %b want 10000", ctl()); end
    tick();
    #2;
    reset = 1'b1;
    idle_in();
    #2;
    all_o = {fields(), ctl(), bus.inst_rdata, bus.data_rdata, 1'b0};
    vectors++;
    if (all_o !== 140'h0) begin miscompares++; $display("FAIL rmid_outputs: got %h want 0", all_o); end
    tick();
    reset = 1'b0;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000_0055;
    #4;
    vectors++;
    if (ctl() !== 5'b00000) begin miscompares++; $display("FAIL rmid_late_ok: got %b want 00000", ctl()); end
    tick();
    bus.mem_data_ok = 1'b0; bus.mem_addr_ok = 1'b1;
    set_data(1'b0, 2'd2, 4'hf, 32'h0000_0100, 32'h0);
    #4;
    vectors++;
    if ({ctl(), bus.mem_addr} !== {5'b10100, 32'h0000_0100}) begin
      miscompares++; $display("FAIL rmid_grant: got %b %h", ctl(), bus.mem_addr); end
    tick();
    idle_in();
    bus.mem_data_ok = 1'b1;
    #4;
    vectors++;
    if (ctl() !== 5'b00001) begin miscompares++; $display("FAIL rmid_resp: got %b want 00001", ctl()); end
    tick();
    idle_in();
  endtask

  task automatic test_arbitration_policy();
    logic exp_g, prev_g;
    logic [4:0] exp_c;
    idle_in();
    set_inst(32'h1c00_0400); set_data(1'b0, 2'd2, 4'hf, 32'h0000_0500, 32'h0);
    bus.mem_addr_ok = 1'b1;
    prev_g = OWNER_INST;
    for (int k = 0; k < 8; k++) begin
      bus.mem_data_ok = (k > 0);
      exp_g = RR ? ((k % 2 == 0) ? OWNER_INST : OWNER_DATA) : OWNER_DATA;
      exp_c = {1'b1, exp_g == OWNER_INST, exp_g == OWNER_DATA,
               (k > 0) && (prev_g == OWNER_INST), (k > 0) && (prev_g == OWNER_DATA)};
      #4;
      vectors++;
      if (ctl() !== exp_c) begin miscompares++; $display("FAIL policy_%0d: got %b want %b", k, ctl(), exp_c); end
      prev_g = exp_g;
      tick();
    end
    idle_in();
    bus.mem_data_ok = 1'b1;
    tick();
    idle_in();
  endtask

  task automatic test_random();
    mtag_t q[$];
    logic locked, lock_own, ptr, g, mreq, popv, dlv;
    logic [4:0] exp_c;
    logic [70:0] exp_f;
    locked = 1'b0; lock_own = OWNER_INST; ptr = OWNER_INST;
    reset = 1'b1; idle_in(); tick(); reset = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!bus.inst_req) begin
        bus.inst_req = ($urandom_range(0, 2) != 0); bus.inst_addr = $urandom;
      end
      if (!bus.data_req) begin
        set_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom), $urandom, $urandom);
        bus.data_req = ($urandom_range(0, 2) != 0);
      end
      bus.mem_addr_ok = ($urandom_range(0, 3) != 0);
      bus.mem_data_ok = ($urandom_range(0, 1) != 0);
      bus.mem_rdata   = $urandom;
      bus.inst_cancel = ($urandom_range(0, 7) == 0);
      #4;
      if (locked) g = lock_own;
      else if (bus.data_req && (!bus.inst_req || !RR || ptr == OWNER_DATA)) g = OWNER_DATA;
      else g = OWNER_INST;
      mreq = ((g == OWNER_DATA) ? bus.data_req : bus.inst_req) && (q.size() < OUTS);
      popv = bus.mem_data_ok && (q.size() > 0);
      dlv  = popv && !q[0].disc && !(bus.inst_cancel && q[0].owner == OWNER_INST);
      exp_c = {mreq, mreq && bus.mem_addr_ok && g == OWNER_INST, mreq && bus.mem_addr_ok && g == OWNER_DATA,
               dlv && q[0].owner == OWNER_INST, dlv && q[0].owner == OWNER_DATA};
      if (g == OWNER_DATA) exp_f = {bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata};
      else if (bus.inst_req) exp_f = {1'b0, 2'b10, 4'h0, bus.inst_addr, 32'h0};
      else exp_f = 71'h0;
      vectors++;
      if (ctl() !== exp_c) begin miscompares++; $display("FAIL rand_ctl@%0d: got %b want %b", n, ctl(), exp_c); end
      vectors++;
      if (fields() !== exp_f) begin miscompares++; $display("FAIL rand_fields@%0d: got %h want %h", n, fields(), exp_f); end
      vectors++;
      if ({bus.inst_rdata, bus.data_rdata} !== {bus.mem_rdata, bus.mem_rdata}) begin
        miscompares++; $display("FAIL rand_rdata@%0d: got %h %h want %h", n, bus.inst_rdata, bus.data_rdata, bus.mem_rdata); end
      if (bus.inst_cancel) begin
        for (int i = 0; i < q.size(); i++) if (q[i].owner == OWNER_INST) q[i].disc = 1'b1;
      end
      if (popv) void'(q.pop_front());
      if (mreq && bus.mem_addr_ok) begin
        q.push_back('{owner: g, disc: 1'b0});
        if (g == ptr) ptr = ~ptr;
      end
      if (!locked && mreq && !bus.mem_addr_ok) begin
        locked = 1'b1; lock_own = g;
      end else if (locked && bus.mem_addr_ok) begin
        locked = 1'b0;
      end
      tick();
      if (exp_c[3]) bus.inst_req = 1'b0;
      if (exp_c[2]) bus.data_req = 1'b0;
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_full();
    test_cancel();
    test_reset_mid();
    test_arbitration_policy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
